garage_motor_sequencer: RTL and testbench
=========================================

# garage_motor_sequencer

Sequences the garage door motor driver from the 2-bit open/close command produced by the door controller FSM. Enforces a soft-start PWM ramp, a controlled ramp-down, a dead time before any direction reversal, hard stop at the limit switches, and latched faults on obstruction or travel timeout. Sits between the door controller and the motor H-bridge; all motor outputs are registered and safe-off in reset.

## Interface
- PWM_BITS, 4: PWM counter width; full duty is 2**PWM_BITS.
- RAMP_STEP_CYCLES, 4: cycles per duty step during ramp up/down (≥1).
- DEAD_CYCLES, 16: motor-off cycles after every stop (≥1).
- TRAVEL_TIMEOUT, 1024: maximum cycles from ramp start to stop before fault.
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- cmd  input  2  door command: 2'b10 open (up), 2'b11 close (down), 2'b0x stop.
- limit_up  input  1  door fully-open switch.
- limit_down  input  1  door fully-closed switch.
- obstruct  input  1  obstruction sensor, active high.
- fault_clr  input  1  fault acknowledge, level.
- motor_en  output  1  H-bridge enable.
- motor_dir  output  1  0 = up, 1 = down (equals cmd[0] latched at start).
- motor_pwm  output  1  PWM drive.
- busy  output  1  state ≠ IDLE.
- fault  output  1  state == FAULT.

## Operation
- States: IDLE, RAMP, RUN, BRAKE, DEAD, FAULT. Reset enters IDLE with duty=0 and all outputs 0.
- IDLE: if cmd[1]=1 and the limit for direction cmd[0] is low, latch dir=cmd[0], clear duty, step and travel counters, and go to RAMP. Otherwise stay.
- RAMP: duty increments by 1 every RAMP_STEP_CYCLES cycles. When duty reaches 2**PWM_BITS, go to RUN.
- RUN: duty held at full.
- Stop request: in RAMP or RUN, cmd[1]=0 or cmd[0]≠dir goes to BRAKE. Duty continues from its current value.
- BRAKE: duty decrements by 1 every RAMP_STEP_CYCLES cycles. When duty reaches 0, go to DEAD. A new cmd during BRAKE is ignored; a reversal is only accepted from IDLE.
- Limit hit: in RAMP, RUN or BRAKE, the limit matching dir sets duty=0 and goes directly to DEAD (hard stop, no ramp).
- DEAD: motor_en=0; count DEAD_CYCLES, then go to IDLE. IDLE evaluates cmd on its first cycle.
- FAULT is entered from RAMP, RUN or BRAKE when:
  - obstruct=1, or
  - the travel counter reaches TRAVEL_TIMEOUT.
- In FAULT: duty=0, motor outputs off. Exit to DEAD only when fault_clr=1 and cmd[1]=0 in the same cycle.
- Priority in the same cycle: obstruct > limit > timeout > cmd.
- motor_en=1 only in RAMP, RUN and BRAKE. motor_dir holds the latched dir in those states and is 0 elsewhere.
- motor_pwm = motor_en & (pwm_cnt < duty).
  - pwm_cnt is a free-running PWM_BITS counter, cleared by reset.
  - duty is PWM_BITS+1 wide, saturating at 0 and at 2**PWM_BITS. Full duty means constant high.
- Travel counter width is $clog2(TRAVEL_TIMEOUT+1). It saturates and is cleared on each IDLE→RAMP transition.
- Step counter is cleared on entry to RAMP and to BRAKE.

## Timing
- Inputs are sampled on the rising clk edge. cmd, limit_up, limit_down, obstruct and fault_clr are synchronous to clk; the upstream block synchronizes them.
- IDLE→RAMP: motor_en=1 in the cycle after the edge that sampled the open/close cmd.
- Ramp up: full ramp takes 2**PWM_BITS × RAMP_STEP_CYCLES cycles (64 at defaults).
- Ramp down: from full duty, BRAKE takes 64 cycles at defaults.
- DEAD lasts exactly DEAD_CYCLES cycles; busy falls in the following cycle.
- Obstruct, limit or timeout removes motor_en one cycle after being sampled.
- rst low at any time, including mid-ramp: motor_en, motor_dir, motor_pwm, busy and fault go to 0 immediately (asynchronously). State returns to IDLE.

## Structure
- Shared package garage_pkg:
  - motor_state_t enum
  - CMD_OPEN=2'b10, CMD_CLOSE=2'b11
  - DIR_UP=1'b0, DIR_DOWN=1'b1
- Sub-module garage_pwm_gen (parameter PWM_BITS): holds the free-running counter and the duty comparator, gated by enable. The FSM, duty register, step counter, dead counter and travel counter stay in garage_motor_sequencer.

## Test plan
All scenarios use default parameters.
- Start up: cmd=2'b10 from IDLE → next cycle motor_en=1, motor_dir=0, busy=1. Duty reaches 16 after 64 cycles, state RUN, motor_pwm constant 1.
- Limit stop: limit_up=1 during RUN → motor_en=0 next cycle; DEAD for 16 cycles; busy=0 on cycle 17.
- Reversal: cmd changes 2'b10→2'b11 during RUN → BRAKE for 64 cycles, DEAD for 16, one IDLE cycle, then RAMP with motor_dir=1.
- Obstruction: obstruct=1 during RAMP → fault=1 and motor_en=0 next cycle.
  - fault_clr=1 with cmd=2'b10: ignored.
  - fault_clr=1 with cmd=2'b00: 16 DEAD cycles, then IDLE, fault=0.
- Timeout: cmd=2'b11 held with no limit → fault=1 when the travel counter reaches 1024.
- Reset mid-RUN: rst=0 → all outputs 0 without a clock edge. After release, cmd=2'b00 keeps IDLE.

Source files
------------

// File: rtl/garage_pkg.sv
// garage_pkg: shared state, command and direction definitions for the garage motor sequencer.
package garage_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RAMP,
    ST_RUN,
    ST_BRAKE,
    ST_DEAD,
    ST_FAULT
  } motor_state_t;
  localparam logic [1:0] CMD_OPEN = 2'b10;
  localparam logic [1:0] CMD_CLOSE = 2'b11;
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DOWN = 1'b1;
  function automatic logic at_limit(logic dir, logic limit_up, logic limit_down);
    return (dir == DIR_DOWN) ? limit_down : limit_up;
  endfunction
endpackage

// File: rtl/garage_motor_sequencer_if.sv
// garage_motor_sequencer_if: door-controller commands/sensors in, H-bridge drive and status out.
interface garage_motor_sequencer_if;
  logic [1:0] cmd;
  logic limit_up;
  logic limit_down;
  logic obstruct;
  logic fault_clr;
  logic motor_en;
  logic motor_dir;
  logic motor_pwm;
  logic busy;
  logic fault;
  modport master (
    output cmd, limit_up, limit_down, obstruct, fault_clr,
    input motor_en, motor_dir, motor_pwm, busy, fault
  );
  modport slave (
    input cmd, limit_up, limit_down, obstruct, fault_clr,
    output motor_en, motor_dir, motor_pwm, busy, fault
  );
endinterface

// File: rtl/garage_pwm_gen.sv
// garage_pwm_gen: free-running PWM counter and duty comparator, gated by enable.
module garage_pwm_gen #(
  parameter int PWM_BITS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [PWM_BITS:0] duty,
  output logic              pwm
);
  logic [PWM_BITS-1:0] cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else cnt <= cnt + 1'b1;
  // duty is one bit wider, so full duty compares true for every count
  assign pwm = en && ({1'b0, cnt} < duty);
endmodule

// File: rtl/garage_motor_sequencer.sv
// garage_motor_sequencer: soft-start/stop motor sequencing with dead time, limit stops and latched faults.
module garage_motor_sequencer
  import garage_pkg::*;
#(
  parameter int PWM_BITS = 4,
  parameter int RAMP_STEP_CYCLES = 4,
  parameter int DEAD_CYCLES = 16,
  parameter int TRAVEL_TIMEOUT = 1024
) (
  input logic clk,
  input logic rst,
  garage_motor_sequencer_if.slave m
);
  localparam int SW = (RAMP_STEP_CYCLES > 1) ? $clog2(RAMP_STEP_CYCLES) : 1;
  localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam int TW = $clog2(TRAVEL_TIMEOUT + 1);
  localparam logic [PWM_BITS:0] FULL = {1'b1, {PWM_BITS{1'b0}}};
  motor_state_t state, state_nxt;
  logic [PWM_BITS:0] duty, duty_nxt;
  logic [SW-1:0] step, step_nxt;
  logic [DW-1:0] dead, dead_nxt;
  logic [TW-1:0] travel, travel_nxt;
  logic dir, dir_nxt;
  logic en_q, dir_q, busy_q, fault_q;
  logic moving, mov_nxt, step_last, lim, stop_req;
  assign moving = state inside {ST_RAMP, ST_RUN, ST_BRAKE};
  assign mov_nxt = state_nxt inside {ST_RAMP, ST_RUN, ST_BRAKE};
  assign step_last = step == SW'(RAMP_STEP_CYCLES - 1);
  assign lim = at_limit(dir, m.limit_up, m.limit_down);
  assign stop_req = !m.cmd[1] || (m.cmd[0] != dir);
  always_comb begin
    state_nxt = state;
    duty_nxt = duty;
    dir_nxt = dir;
    dead_nxt = dead;
    step_nxt = step_last ? '0 : step + 1'b1;
    travel_nxt = (moving && travel != '1) ? travel + 1'b1 : travel;
    case (state)
      ST_IDLE:
        if (m.cmd[1] && !at_limit(m.cmd[0], m.limit_up, m.limit_down)) begin
          state_nxt = ST_RAMP;
          dir_nxt = m.cmd[0];
          duty_nxt = '0;
          step_nxt = '0;
          travel_nxt = '0;
        end
      ST_RAMP, ST_RUN, ST_BRAKE:
        if (m.obstruct) begin
          state_nxt = ST_FAULT;
          duty_nxt = '0;
        end else if (lim) begin
          state_nxt = ST_DEAD;
          duty_nxt = '0;
          dead_nxt = '0;
        end else if (travel == TW'(TRAVEL_TIMEOUT)) begin
          state_nxt = ST_FAULT;
          duty_nxt = '0;
        end else if (state != ST_BRAKE && stop_req) begin
          state_nxt = ST_BRAKE;
          step_nxt = '0;
        end else if (state == ST_RAMP && step_last) begin
          duty_nxt = duty + 1'b1;
          state_nxt = (duty + 1'b1 == FULL) ? ST_RUN : ST_RAMP;
        end else if (state == ST_BRAKE && (duty == '0 || (step_last && duty == 1))) begin
          state_nxt = ST_DEAD;
          duty_nxt = '0;
          dead_nxt = '0;
        end else if (state == ST_BRAKE && step_last) begin
          duty_nxt = duty - 1'b1;
        end
      ST_DEAD:
        if (dead == DW'(DEAD_CYCLES - 1)) state_nxt = ST_IDLE;
        else dead_nxt = dead + 1'b1;
      ST_FAULT: begin
        duty_nxt = '0;
        if (m.fault_clr && !m.cmd[1]) begin
          state_nxt = ST_DEAD;
          dead_nxt = '0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        duty_nxt = '0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= ST_IDLE;
      duty <= '0;
      step <= '0;
      dead <= '0;
      travel <= '0;
      dir <= DIR_UP;
      en_q <= 1'b0;
      dir_q <= 1'b0;
      busy_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state <= state_nxt;
      duty <= duty_nxt;
      step <= step_nxt;
      dead <= dead_nxt;
      travel <= travel_nxt;
      dir <= dir_nxt;
      en_q <= mov_nxt;
      dir_q <= mov_nxt && dir_nxt;
      busy_q <= state_nxt != ST_IDLE;
      fault_q <= state_nxt == ST_FAULT;
    end
  assign m.motor_en = en_q;
  assign m.motor_dir = dir_q;
  assign m.busy = busy_q;
  assign m.fault = fault_q;
  garage_pwm_gen #(.PWM_BITS(PWM_BITS)) u_pwm (
    .clk(clk),
    .rst(rst),
    .en(en_q),
    .duty(duty),
    .pwm(m.motor_pwm)
  );
endmodule

// File: tb/tb_garage_motor_sequencer.sv
// tb_garage_motor_sequencer: directed scenarios plus random stimulus against a phase/elapsed-time model.
module tb_garage_motor_sequencer;
  localparam int FULL_D = 16;
  localparam int STEP = 4;
  localparam int DEADN = 16;
  localparam int TMO = 1024;
  logic clk = 0;
  logic rst = 0;
  logic [1:0] cmd = 2'b00;
  logic lu = 0, ld = 0, obs = 0, fclr = 0;
  int n_vec = 0, n_err = 0;
  string ph = "IDLE";
  int t = 0, d0 = 0, trav = 0, pc = 0;
  bit mdir = 0;
  garage_motor_sequencer_if bus ();
  assign bus.cmd = cmd;
  assign bus.limit_up = lu;
  assign bus.limit_down = ld;
  assign bus.obstruct = obs;
  assign bus.fault_clr = fclr;
  garage_motor_sequencer dut (.clk(clk), .rst(rst), .m(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit motoring();
    return ph == "RAMP" || ph == "RUN" || ph == "BRAKE";
  endfunction

  function automatic int cur_duty();
    if (ph == "RAMP") return (t / STEP > FULL_D) ? FULL_D : t / STEP;
    if (ph == "RUN") return FULL_D;
    if (ph == "BRAKE") return (d0 - t / STEP < 0) ? 0 : d0 - t / STEP;
    return 0;
  endfunction

  function automatic logic [4:0] expect_out();
    bit en = motoring();
    return {en, en & mdir, en && (pc < cur_duty()), ph != "IDLE", ph == "FAULT"};
  endfunction

  function automatic logic [4:0] dut_out();
    return {bus.motor_en, bus.motor_dir, bus.motor_pwm, bus.busy, bus.fault};
  endfunction

  task automatic model_reset();
    ph = "IDLE"; t = 0; d0 = 0; trav = 0; pc = 0; mdir = 0;
  endtask

  task automatic model_edge();
    string nx = ph;
    int dd = cur_duty();
    bit lim = mdir ? ld : lu;
    if (ph == "IDLE") begin
      if (cmd[1] && !(cmd[0] ? ld : lu)) begin
        nx = "RAMP"; mdir = cmd[0]; trav = 0;
      end
    end else if (motoring()) begin
      if (obs) nx = "FAULT";
      else if (lim) nx = "DEAD";
      else if (trav >= TMO) nx = "FAULT";
      else if (ph != "BRAKE" && (!cmd[1] || cmd[0] != mdir)) begin
        nx = "BRAKE"; d0 = dd;
      end else if (ph == "RAMP" && (t + 1) / STEP >= FULL_D) nx = "RUN";
      else if (ph == "BRAKE" && d0 - (t + 1) / STEP <= 0) nx = "DEAD";
      trav++;
    end else if (ph == "DEAD") begin
      if (t + 1 >= DEADN) nx = "IDLE";
    end else if (fclr && !cmd[1]) nx = "DEAD";
    t = (nx == ph) ? t + 1 : 0;
    ph = nx;
    pc = (pc + 1) % 16;
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk(tag, 32'(dut_out()), 32'(expect_out()));
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  initial begin
    int cnt;
    model_reset();
    #12;
    chk("reset_outs", 32'(dut_out()), 32'd0);
    @(negedge clk);
    rst = 1;
    run("idle", 3);
    cmd = 2'b10;
    cycle("start");
    chk("start_en_dir_busy", 32'({bus.motor_en, bus.motor_dir, bus.busy}), 32'b101);
    run("ramp_up", 63);
    chk("ramp_done_pwm", 32'({bus.motor_en, bus.motor_pwm}), 32'b11);
    run("run", 20);
    lu = 1;
    cycle("limit_hit");
    chk("limit_en_off", 32'({bus.motor_en, bus.busy}), 32'b01);
    lu = 0; cmd = 2'b00;
    cnt = 1;
    while (bus.busy && cnt < 100) begin
      cycle("limit_dead");
      if (bus.busy) cnt++;
    end
    chk("dead_len", 32'(cnt), 32'(DEADN));
    cmd = 2'b10;
    run("rev_ramp", 80);
    cmd = 2'b11;
    run("rev_brake_dead", 64 + 16 + 1);
    cycle("rev_start");
    chk("rev_dir", 32'({bus.motor_en, bus.motor_dir}), 32'b11);
    cmd = 2'b00;
    run("rev_stop", 100);
    cmd = 2'b10;
    run("obs_ramp", 10);
    obs = 1;
    cycle("obs_hit");
    chk("obs_fault", 32'({bus.fault, bus.motor_en}), 32'b10);
    obs = 0; fclr = 1;
    run("obs_clr_ignored", 5);
    chk("obs_still_fault", 32'(bus.fault), 32'd1);
    cmd = 2'b00;
    run("obs_clr", 17);
    chk("obs_cleared", 32'({bus.fault, bus.busy}), 32'b00);
    fclr = 0;
    cmd = 2'b11;
    run("timeout", 1100);
    chk("timeout_fault", 32'(bus.fault), 32'd1);
    cmd = 2'b00; fclr = 1;
    run("timeout_clr", 20);
    fclr = 0;
    cmd = 2'b10;
    run("pre_reset", 80);
    #2 rst = 0;
    #1 chk("async_reset", 32'(dut_out()), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1; cmd = 2'b00;
    run("post_reset_idle", 5);
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 149) == 0) cmd = 2'($urandom_range(0, 3));
      lu = $urandom_range(0, 399) == 0;
      ld = $urandom_range(0, 399) == 0;
      obs = $urandom_range(0, 799) == 0;
      fclr = $urandom_range(0, 15) == 0;
      cycle("random");
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
